// File: rtl/airlock_pkg.sv
// Airlock controller shared definitions: state encoding, err_code values and
// small state-class helpers used by the FSM and its output decode.
package airlock_pkg;

  typedef enum logic [3:0] {
    S_INIT             = 4'h0,
    S_PREP             = 4'h1,
    S_WAIT_FILL        = 4'h2,
    S_FILLING          = 4'h3,
    S_WAIT_IPORT_OPEN  = 4'h4,
    S_WAIT_OPORT_OPEN  = 4'h5,
    S_WAIT_DRAIN       = 4'h6,
    S_DRAINING         = 4'h7,
    S_WAIT_IPORT_CLOSE = 4'h8,
    S_WAIT_OPORT_CLOSE = 4'h9,
    S_WAIT_USER        = 4'hA,
    S_ERROR            = 4'hB
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DIFF    = 2'b01;
  localparam logic [1:0] ERR_LIMIT   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // States with a fixed dwell time.
  function automatic logic is_timed(input state_e s);
    return (s == S_PREP) || (s == S_FILLING) || (s == S_DRAINING);
  endfunction

  // States that wait on an operator or port event.
  function automatic logic is_wait(input state_e s);
    return (s == S_WAIT_FILL)        || (s == S_WAIT_OPORT_OPEN) ||
           (s == S_WAIT_OPORT_CLOSE) || (s == S_WAIT_DRAIN)      ||
           (s == S_WAIT_IPORT_OPEN)  || (s == S_WAIT_IPORT_CLOSE);
  endfunction

endpackage

// File: rtl/airlock_timer.sv
// Dwell timer: CW-bit up-counter with synchronous clear and count enable.
// done_o flags the last cycle of an N-cycle dwell (count == N-1).
// Ports: clock, reset (sync, active-high), clr_i, en_i, n_i (dwell length),
//        cnt_o (current count), done_o.
module airlock_timer #(
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] n_i,
  output logic [CW-1:0] cnt_o,
  output logic          done_o
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset || clr_i) cnt_q <= '0;
    else if (en_i)      cnt_q <= cnt_q + ONE;
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == (n_i - ONE));

endmodule

// File: rtl/airlock_ctrl.sv
// Airlock controller: Moore FSM sequencing a vessel through the airlock
// (prep, fill, outer port cycle, drain, inner port cycle) with interlock and
// pressure-fault handling.
// Ports: clock, reset (sync, active-high); arrive/depart/fill/drain operator
//        requests; iport/oport port status; diff_err/limit_err faults; clear
//        error acknowledge. Outputs: state code, dir (0 arrival, 1 departure),
//        busy_led, progress (timer in timed states), err_code.
// Build option: define AIRLOCK_TIMEOUT_EN to make wait states fault with
//        err_code=11 after TIMEOUT_CYC cycles; otherwise they wait forever.
module airlock_ctrl
  import airlock_pkg::*;
#(
  parameter int CW          = 16,
  parameter int PREP_CYC    = 32,
  parameter int FILL_CYC    = 48,
  parameter int DRAIN_CYC   = 64,
  parameter int BLINK_LOG2  = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          arrive,
  input  logic          depart,
  input  logic          fill,
  input  logic          drain,
  input  logic          iport,
  input  logic          oport,
  input  logic          diff_err,
  input  logic          limit_err,
  input  logic          clear,
  output logic [3:0]    state,
  output logic          dir,
  output logic          busy_led,
  output logic [CW-1:0] progress,
  output logic [1:0]    err_code
);

  state_e        state_q, state_d;
  logic          dir_q, dir_d;
  logic [1:0]    err_q, err_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] dwell_n;
  logic          dwell_done;
  logic          timed;

  assign timed = is_timed(state_q);

  always_comb begin
    dwell_n = CW'(PREP_CYC);
    case (state_q)
      S_FILLING:  dwell_n = CW'(FILL_CYC);
      S_DRAINING: dwell_n = CW'(DRAIN_CYC);
      default:    dwell_n = CW'(PREP_CYC);
    endcase
  end

  // Timer restarts on every state change so each state sees a fresh count.
  airlock_timer #(.CW(CW)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clr_i  (state_d != state_q),
    .en_i   (timed || is_wait(state_q)),
    .n_i    (dwell_n),
    .cnt_o  (cnt),
    .done_o (dwell_done)
  );

`ifdef AIRLOCK_TIMEOUT_EN
  logic tmo;
  assign tmo = is_wait(state_q) && (cnt == CW'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    err_d   = err_q;
    // Interlock: both ports open, or inner port open while pressure changes.
    if ((state_q != S_ERROR) &&
        ((iport && oport) ||
         (iport && ((state_q == S_FILLING) || (state_q == S_DRAINING))))) begin
      state_d = S_ERROR;
      err_d   = ERR_DIFF;
    end
`ifdef AIRLOCK_TIMEOUT_EN
    else if (tmo) begin
      state_d = S_ERROR;
      err_d   = ERR_TIMEOUT;
    end
`endif
    else begin
      case (state_q)
        S_INIT: begin
          if (arrive) begin
            state_d = S_PREP;
            dir_d   = 1'b0;
          end else if (iport) begin
            state_d = S_WAIT_USER;
          end
        end
        S_WAIT_USER: begin
          if (depart && !iport) begin
            state_d = S_PREP;
            dir_d   = 1'b1;
          end
        end
        S_PREP:
          if (dwell_done) state_d = S_WAIT_FILL;
        S_WAIT_FILL:
          if (fill && !arrive && !depart) state_d = S_FILLING;
        S_FILLING: begin
          if (limit_err) begin
            state_d = S_ERROR;
            err_d   = ERR_LIMIT;
          end else if (dwell_done) begin
            state_d = S_WAIT_OPORT_OPEN;
          end
        end
        S_WAIT_OPORT_OPEN: begin
          if (diff_err) begin
            state_d = S_ERROR;
            err_d   = ERR_DIFF;
          end else if (oport) begin
            state_d = S_WAIT_OPORT_CLOSE;
          end
        end
        S_WAIT_OPORT_CLOSE:
          if (!oport) state_d = S_WAIT_DRAIN;
        S_WAIT_DRAIN:
          if (drain) state_d = S_DRAINING;
        S_DRAINING: begin
          if (limit_err) begin
            state_d = S_ERROR;
            err_d   = ERR_LIMIT;
          end else if (dwell_done) begin
            state_d = S_WAIT_IPORT_OPEN;
          end
        end
        S_WAIT_IPORT_OPEN: begin
          if (diff_err) begin
            state_d = S_ERROR;
            err_d   = ERR_DIFF;
          end else if (iport) begin
            state_d = S_WAIT_IPORT_CLOSE;
          end
        end
        S_WAIT_IPORT_CLOSE:
          if (!iport) state_d = S_INIT;
        S_ERROR: begin
          if (clear && !iport && !oport && !diff_err && !limit_err) begin
            state_d = S_INIT;
            err_d   = ERR_NONE;
          end
        end
        // Unused codes C-F recover through ERROR.
        default: state_d = S_ERROR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INIT;
      dir_q   <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign state    = state_q;
  assign dir      = dir_q;
  assign err_code = err_q;
  assign busy_led = timed & cnt[BLINK_LOG2];
  assign progress = timed ? cnt : '0;

endmodule

// File: tb/tb_airlock_ctrl.sv
module tb_airlock_ctrl;

  localparam int CW   = 16;
  localparam int BL   = 2;
  localparam int PREP = 4;
  localparam int FILL = 6;
  localparam int DRN  = 8;
  localparam int TMO  = 20;

  logic          clock = 1'b0;
  logic          reset, arrive, depart, fill, drain, iport, oport;
  logic          diff_err, limit_err, clear;
  logic [3:0]    state;
  logic          dir, busy_led;
  logic [CW-1:0] progress;
  logic [1:0]    err_code;

  int checks = 0;
  int errors = 0;

  logic       exp_dir;
  logic [1:0] exp_err;

  typedef struct {
    logic [3:0]    st;
    logic          d;
    logic [1:0]    e;
    logic          led;
    logic [CW-1:0] prog;
    string         tag;
  } exp_t;

  exp_t sb[$];

  airlock_ctrl #(
    .CW(CW), .PREP_CYC(PREP), .FILL_CYC(FILL), .DRAIN_CYC(DRN),
    .BLINK_LOG2(BL), .TIMEOUT_CYC(TMO)
  ) dut (
    .clock(clock), .reset(reset), .arrive(arrive), .depart(depart),
    .fill(fill), .drain(drain), .iport(iport), .oport(oport),
    .diff_err(diff_err), .limit_err(limit_err), .clear(clear),
    .state(state), .dir(dir), .busy_led(busy_led), .progress(progress),
    .err_code(err_code)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic timed_st(input logic [3:0] s);
    return (s == 4'h1) || (s == 4'h3) || (s == 4'h7);
  endfunction

  // Push the expectation for the next edge, clock once, then pop and compare.
  task automatic step(input logic [3:0] st, input int p, input string tag);
    exp_t x;
    x.st   = st;
    x.d    = exp_dir;
    x.e    = exp_err;
    x.prog = timed_st(st) ? p[CW-1:0] : '0;
    x.led  = timed_st(st) ? x.prog[BL] : 1'b0;
    x.tag  = tag;
    sb.push_back(x);
    @(posedge clock);
    #1;
    x = sb.pop_front();
    checks++;
    assert (state === x.st) else begin
      errors++; $error("FAIL %s state got %0h exp %0h", x.tag, state, x.st);
    end
    checks++;
    assert (dir === x.d) else begin
      errors++; $error("FAIL %s dir got %0b exp %0b", x.tag, dir, x.d);
    end
    checks++;
    assert (err_code === x.e) else begin
      errors++; $error("FAIL %s err_code got %0b exp %0b", x.tag, err_code, x.e);
    end
    checks++;
    assert (progress === x.prog) else begin
      errors++; $error("FAIL %s progress got %0d exp %0d", x.tag, progress, x.prog);
    end
    checks++;
    assert (busy_led === x.led) else begin
      errors++; $error("FAIL %s busy_led got %0b exp %0b", x.tag, busy_led, x.led);
    end
  endtask

  // Remaining cycles of a timed state already entered (count 0 seen).
  task automatic timed_run(input logic [3:0] st, input int n, input string tag);
    for (int i = 1; i < n; i++) step(st, i, tag);
  endtask

  // From PREP entry through fill, outer port cycle, up to WAIT_DRAIN.
  task automatic prep_to_wait_drain(input string tag);
    timed_run(4'h1, PREP, {tag, "_prep"});
    step(4'h2, 0, {tag, "_wfill"});
    fill = 1'b1;
    step(4'h3, 0, {tag, "_fill0"});
    fill = 1'b0;
    timed_run(4'h3, FILL, {tag, "_fill"});
    step(4'h5, 0, {tag, "_woo"});
    oport = 1'b1;
    step(4'h9, 0, {tag, "_woc"});
    oport = 1'b0;
    step(4'h6, 0, {tag, "_wdrain"});
  endtask

  // From WAIT_DRAIN through draining and inner port cycle back to INIT.
  task automatic drain_to_init(input string tag);
    drain = 1'b1;
    step(4'h7, 0, {tag, "_drn0"});
    drain = 1'b0;
    timed_run(4'h7, DRN, {tag, "_drn"});
    step(4'h4, 0, {tag, "_wio"});
    iport = 1'b1;
    step(4'h8, 0, {tag, "_wic"});
    iport = 1'b0;
    step(4'h0, 0, {tag, "_init"});
  endtask

  task automatic arrive_to_wait_drain(input string tag);
    arrive  = 1'b1;
    exp_dir = 1'b0;
    step(4'h1, 0, {tag, "_prep0"});
    arrive = 1'b0;
    prep_to_wait_drain(tag);
  endtask

  initial begin
    reset = 1'b1; arrive = 1'b0; depart = 1'b0; fill = 1'b0; drain = 1'b0;
    iport = 1'b0; oport = 1'b0; diff_err = 1'b0; limit_err = 1'b0; clear = 1'b0;
    exp_dir = 1'b0; exp_err = 2'b00;
    @(negedge clock);
    step(4'h0, 0, "reset");
    reset = 1'b0;
    step(4'h0, 0, "idle");

    // Arrival: 0,1,2,3,5,9,6,7,4,8,0
    arrive_to_wait_drain("arr");
    drain_to_init("arr");

    // Departure
    iport = 1'b1;
    step(4'hA, 0, "dep_user");
    step(4'hA, 0, "dep_user_hold");
    iport = 1'b0; depart = 1'b1; exp_dir = 1'b1;
    step(4'h1, 0, "dep_prep0");
    depart = 1'b0;
    prep_to_wait_drain("dep");
    drain_to_init("dep");

    // Limit fault on the 3rd FILLING cycle
    arrive = 1'b1; exp_dir = 1'b0;
    step(4'h1, 0, "lim_prep0");
    arrive = 1'b0;
    timed_run(4'h1, PREP, "lim_prep");
    step(4'h2, 0, "lim_wfill");
    fill = 1'b1;
    step(4'h3, 0, "lim_fill0");
    fill = 1'b0;
    step(4'h3, 1, "lim_fill1");
    step(4'h3, 2, "lim_fill2");
    limit_err = 1'b1; exp_err = 2'b10;
    step(4'hB, 0, "lim_err");
    clear = 1'b1;
    step(4'hB, 0, "lim_clear_fault_held");
    limit_err = 1'b0; exp_err = 2'b00;
    step(4'h0, 0, "lim_clear");
    clear = 1'b0;

    // Interlock in WAIT_OPORT_OPEN
    arrive = 1'b1;
    step(4'h1, 0, "ilk_prep0");
    arrive = 1'b0;
    timed_run(4'h1, PREP, "ilk_prep");
    step(4'h2, 0, "ilk_wfill");
    fill = 1'b1;
    step(4'h3, 0, "ilk_fill0");
    fill = 1'b0;
    timed_run(4'h3, FILL, "ilk_fill");
    step(4'h5, 0, "ilk_woo");
    iport = 1'b1; oport = 1'b1; exp_err = 2'b01;
    step(4'hB, 0, "ilk_err");
    iport = 1'b0; clear = 1'b1;
    step(4'hB, 0, "ilk_clear_oport");
    oport = 1'b0; exp_err = 2'b00;
    step(4'h0, 0, "ilk_clear");
    clear = 1'b0;

    // Idle in WAIT_DRAIN
    arrive_to_wait_drain("tmo");
    for (int i = 1; i < TMO; i++) step(4'h6, 0, "tmo_wait");
`ifdef AIRLOCK_TIMEOUT_EN
    exp_err = 2'b11;
    step(4'hB, 0, "tmo_err");
`else
    step(4'h6, 0, "tmo_none");
`endif
    step(timed_st(4'h6) ? 4'h0 : state_after_tmo(), 0, "tmo_hold");
    reset = 1'b1; exp_dir = 1'b0; exp_err = 2'b00;
    step(4'h0, 0, "tmo_reset");
    reset = 1'b0;

    // Reset mid-DRAINING (with blink high)
    arrive_to_wait_drain("rst");
    drain = 1'b1;
    step(4'h7, 0, "rst_drn0");
    drain = 1'b0; limit_err = 1'b0;
    for (int i = 1; i <= 5; i++) step(4'h7, i, "rst_drn");
    reset = 1'b1; arrive = 1'b1;
    step(4'h0, 0, "rst_mid_drain");
    reset = 1'b0; arrive = 1'b0;
    step(4'h0, 0, "rst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [3:0] state_after_tmo();
`ifdef AIRLOCK_TIMEOUT_EN
    return 4'hB;
`else
    return 4'h6;
`endif
  endfunction

endmodule
